hex_cmd_decoder: RTL and testbench

HEX_CMD_DECODER -- requirements
Module: hex_cmd_decoder

---
 rtl/usb_dbg_pkg.sv | 36 +++
 rtl/byte_fifo.sv | 53 +++++
 rtl/hex_cmd_decoder.sv | 109 ++++++++++
 tb/tb_hex_cmd_decoder.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_dbg_pkg.sv
// Shared constants and types for the USB debug command path.
package usb_dbg_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic {ST_IDLE = 1'b0, ST_HI = 1'b1} dec_state_t;

  typedef enum logic [1:0] {CH_HEX, CH_TERM, CH_SEP, CH_ERR} char_kind_t;

  typedef struct packed {
    char_kind_t kind;
    logic [3:0] nib;
  } char_class_t;

  // Letters 'A'-'F' and 'a'-'f' share low nibbles 1-6, so adding 9 yields 10-15.
  function automatic char_class_t classify(input logic [7:0] c);
    char_class_t r;
    r.kind = CH_ERR;
    r.nib  = 4'h0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r.kind = CH_HEX;
      r.nib  = c[3:0];
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      r.kind = CH_HEX;
      r.nib  = c[3:0] + 4'd9;
    end else if (c == ASCII_CR || c == ASCII_LF) begin
      r.kind = CH_TERM;
    end else if (c == ASCII_SP) begin
      r.kind = CH_SEP;
    end
    return r;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// First-word fall-through FIFO; the head is read asynchronously from the array.
module byte_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk48,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);
  import usb_dbg_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd_en && !empty;
  // A pop frees the slot in the same cycle, so a push into a full FIFO may proceed.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk48) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hex_cmd_decoder.sv
// Turns ASCII hex command lines into a byte stream tagged with end-of-line.
module hex_cmd_decoder #(
  parameter int DEPTH = 16
) (
  input  logic       clk48,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_v,
  output logic [7:0] dout,
  output logic       dout_last,
  output logic       dout_v,
  input  logic       dout_rdy,
  output logic       err_char,
  output logic       overflow
);
  import usb_dbg_pkg::*;

  dec_state_t  state;
  char_class_t cc;
  logic        din_v_q;
  logic        accept;
  logic [3:0]  hi_nib;
  logic        pend_v;
  logic [7:0]  pend_byte;
  logic        push;
  logic [8:0]  push_data;
  logic [8:0]  head;
  logic        fifo_empty;
  logic        fifo_full;
  logic        pop;

  assign accept = din_v && !din_v_q;
  assign cc     = classify(din);
  assign pop    = dout_v && dout_rdy;

  // The pending byte leaves either when a newer byte displaces it or when the line ends.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    if (accept) begin
      if (cc.kind == CH_HEX && state == ST_HI && pend_v) begin
        push      = 1'b1;
        push_data = {1'b0, pend_byte};
      end else if (cc.kind == CH_TERM && pend_v) begin
        push      = 1'b1;
        push_data = {1'b1, pend_byte};
      end
    end
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      state     <= ST_IDLE;
      din_v_q   <= 1'b1;
      hi_nib    <= '0;
      pend_v    <= 1'b0;
      pend_byte <= '0;
      err_char  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      din_v_q  <= din_v;
      err_char <= 1'b0;
      if (push && fifo_full && !pop) overflow <= 1'b1;
      if (accept) begin
        case (state)
          ST_IDLE: begin
            if (cc.kind == CH_HEX) begin
              hi_nib <= cc.nib;
              state  <= ST_HI;
            end else if (cc.kind == CH_ERR) begin
              err_char <= 1'b1;
            end
          end
          ST_HI: begin
            state <= ST_IDLE;
            if (cc.kind == CH_HEX) begin
              pend_byte <= {hi_nib, cc.nib};
              pend_v    <= 1'b1;
            end else begin
              err_char <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
        // A second terminator (LF after CR) finds nothing pending and so adds no extra last.
        if (cc.kind == CH_TERM) pend_v <= 1'b0;
      end
    end
  end

  byte_fifo #(
    .WIDTH (9),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk48   (clk48),
    .rst     (rst),
    .wr_data (push_data),
    .wr_en   (push),
    .rd_en   (dout_rdy),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign dout_v    = !fifo_empty;
  assign dout      = head[7:0];
  assign dout_last = head[8];

endmodule

// File: tb/tb_hex_cmd_decoder.sv
// Randomised bench for hex_cmd_decoder against a character-level line model.
module tb_hex_cmd_decoder;

  localparam int DEPTH = 16;

  logic       clk48;
  logic       rst;
  logic [7:0] din;
  logic       din_v;
  logic [7:0] dout;
  logic       dout_last;
  logic       dout_v;
  logic       dout_rdy;
  logic       err_char;
  logic       overflow;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] exp_q [$];
  logic [8:0] got_q [$];
  int  exp_err;
  int  err_seen;
  bit  exp_ovf;
  bit  stall_model;
  bit  rand_rdy;
  int  held;
  int  pend;
  string hexchars = "0123456789ABCDEFabcdef";
  string badchars = "GZ!@x.g-";

  hex_cmd_decoder #(.DEPTH(DEPTH)) dut (
    .clk48     (clk48),
    .rst       (rst),
    .din       (din),
    .din_v     (din_v),
    .dout      (dout),
    .dout_last (dout_last),
    .dout_v    (dout_v),
    .dout_rdy  (dout_rdy),
    .err_char  (err_char),
    .overflow  (overflow)
  );

  initial clk48 = 1'b0;
  always #10 clk48 = ~clk48;

  // Observe pops and error pulses mid-cycle, when everything driven after the last edge has settled.
  always @(negedge clk48) begin
    if (!rst) begin
      if (dout_v && dout_rdy) got_q.push_back({dout_last, dout});
      if (err_char) err_seen++;
    end
  end

  task automatic tick();
    @(posedge clk48);
    #2;
    if (rand_rdy) dout_rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic model_clear();
    held = -1;
    pend = -1;
    exp_err = 0;
    exp_ovf = 0;
    err_seen = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic model_push(input int b, input bit last);
    logic [7:0] b8;
    b8 = 8'(b);
    if (stall_model && exp_q.size() >= DEPTH) exp_ovf = 1;
    else exp_q.push_back({last, b8});
  endtask

  task automatic model_char(input logic [7:0] c);
    int ci;
    int nib;
    bit is_term;
    ci = int'(c);
    nib = -1;
    is_term = (ci == 13 || ci == 10);
    if (ci >= 48 && ci <= 57) nib = ci - 48;
    else if (ci >= 65 && ci <= 70) nib = ci - 65 + 10;
    else if (ci >= 97 && ci <= 102) nib = ci - 97 + 10;
    if (nib >= 0) begin
      if (held < 0) held = nib;
      else begin
        if (pend >= 0) model_push(pend, 1'b0);
        pend = held * 16 + nib;
        held = -1;
      end
    end else begin
      if (held >= 0 || !(is_term || ci == 32)) exp_err++;
      held = -1;
      if (is_term && pend >= 0) begin
        model_push(pend, 1'b1);
        pend = -1;
      end
    end
  endtask

  task automatic send_char(input logic [7:0] c, input int hold, input int gap);
    din = c;
    din_v = 1'b1;
    repeat (hold) tick();
    din_v = 1'b0;
    repeat (gap) tick();
    model_char(c);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i], $urandom_range(1, 3), $urandom_range(1, 2));
  endtask

  task automatic send_nibble(input logic [3:0] n);
    int idx;
    idx = int'(n);
    if (idx >= 10 && $urandom_range(0, 1) == 1) idx += 6;
    send_char(hexchars[idx], $urandom_range(1, 2), 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nibble(b[7:4]);
    send_nibble(b[3:0]);
    send_char(8'h20, 1, 1);
  endtask

  task automatic apply_reset(input logic hold_v);
    rst = 1'b1;
    din_v = hold_v;
    rand_rdy = 0;
    dout_rdy = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    model_clear();
  endtask

  task automatic drain();
    rand_rdy = 0;
    dout_rdy = 1'b1;
    repeat (2 * DEPTH + 10) tick();
  endtask

  task automatic test_reset();
    din = 8'h00;
    stall_model = 0;
    apply_reset(1'b0);
    n_checks++; if (dout_v !== 1'b0) $display("FAIL reset_dout_v got=%b exp=0", dout_v); else n_pass++;
    n_checks++; if (dout !== 8'h00) $display("FAIL reset_dout got=%h exp=00", dout); else n_pass++;
    n_checks++; if (dout_last !== 1'b0) $display("FAIL reset_dout_last got=%b exp=0", dout_last); else n_pass++;
    n_checks++; if (err_char !== 1'b0) $display("FAIL reset_err_char got=%b exp=0", err_char); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow); else n_pass++;
  endtask

  task automatic test_basic_line();
    apply_reset(1'b0);
    dout_rdy = 1'b1;
    send_str("12 ab\r");
    send_str("C0 de\r\n");
    drain();
    n_checks++; if (err_seen !== exp_err) $display("FAIL basic_err got=%0d exp=%0d", err_seen, exp_err); else n_pass++;
    n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL basic_byte[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_odd_nibble();
    apply_reset(1'b0);
    dout_rdy = 1'b1;
    send_str("1 2\n");
    drain();
    n_checks++; if (err_seen !== exp_err) $display("FAIL odd_err got=%0d exp=%0d", err_seen, exp_err); else n_pass++;
    n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL odd_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
  endtask

  task automatic test_bad_char();
    apply_reset(1'b0);
    dout_rdy = 1'b0;
    send_str("4G5\r");
    tick();
    n_checks++; if (dout_v !== 1'b0) $display("FAIL bad_empty dout_v got=%b exp=0", dout_v); else n_pass++;
    n_checks++; if (err_seen !== exp_err) $display("FAIL bad_err got=%0d exp=%0d", err_seen, exp_err); else n_pass++;
  endtask

  task automatic test_backpressure();
    apply_reset(1'b0);
    stall_model = 1;
    for (int i = 0; i < DEPTH + 1; i++) send_byte(8'($urandom_range(0, 255)));
    send_str("\r");
    tick();
    n_checks++; if (dout_v !== 1'b1) $display("FAIL bp_head_valid got=%b exp=1", dout_v); else n_pass++;
    n_checks++; if ({dout_last, dout} !== exp_q[0]) $display("FAIL bp_head got=%h exp=%h", {dout_last, dout}, exp_q[0]); else n_pass++;
    n_checks++; if (overflow !== exp_ovf) $display("FAIL bp_overflow got=%b exp=%b", overflow, exp_ovf); else n_pass++;
    stall_model = 0;
    drain();
    n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL bp_byte[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (dout_v !== 1'b0) $display("FAIL bp_drained dout_v got=%b exp=0", dout_v); else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [7:0] b;
    apply_reset(1'b0);
    stall_model = 1;
    for (int i = 0; i < DEPTH + 1; i++) send_byte(8'($urandom_range(0, 255)));
    n_checks++; if (dut.fifo_full !== 1'b1) $display("FAIL sim_full got=%b exp=1", dut.fifo_full); else n_pass++;
    // The completing digit lands on the same edge as the first pop of the full FIFO.
    b = 8'($urandom_range(0, 255));
    send_nibble(b[7:4]);
    stall_model = 0;
    dout_rdy = 1'b1;
    send_nibble(b[3:0]);
    send_char(8'h20, 1, 1);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 255)));
    send_str("\n");
    drain();
    n_checks++; if (overflow !== 1'b0) $display("FAIL sim_overflow got=%b exp=0", overflow); else n_pass++;
    n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL sim_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL sim_byte[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int r;
    logic [7:0] c;
    apply_reset(1'b0);
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) c = hexchars[$urandom_range(0, 21)];
      else if (r < 80) c = 8'h20;
      else if (r < 85) c = 8'h0D;
      else if (r < 90) c = 8'h0A;
      else c = badchars[$urandom_range(0, 7)];
      send_char(c, $urandom_range(1, 3), $urandom_range(1, 2));
    end
    send_str("\r");
    drain();
    n_checks++; if (err_seen !== exp_err) $display("FAIL rand_err got=%0d exp=%0d", err_seen, exp_err); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL rand_overflow got=%b exp=0", overflow); else n_pass++;
    n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL rand_byte[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midline();
    apply_reset(1'b0);
    dout_rdy = 1'b1;
    send_str("3F");
    din = 8'h41;
    din_v = 1'b1;
    tick();
    apply_reset(1'b1);
    dout_rdy = 1'b1;
    repeat (4) tick();
    din_v = 1'b0;
    tick();
    n_checks++; if (dout_v !== 1'b0) $display("FAIL mid_dout_v got=%b exp=0", dout_v); else n_pass++;
    n_checks++; if (dut.state !== 1'b0) $display("FAIL mid_state got=%b exp=idle", dut.state); else n_pass++;
    send_str("\r");
    drain();
    n_checks++; if (err_seen !== 0) $display("FAIL mid_err got=%0d exp=0", err_seen); else n_pass++;
    n_checks++; if (got_q.size() != 0) $display("FAIL mid_pops got=%0d exp=0", got_q.size()); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    din = 8'h00;
    din_v = 1'b0;
    dout_rdy = 1'b0;
    rand_rdy = 0;
    stall_model = 0;
    model_clear();
    $display("[TB] hex_cmd_decoder bench start");
    test_reset();
    test_basic_line();
    test_odd_nibble();
    test_bad_char();
    test_backpressure();
    test_simultaneous();
    test_random();
    test_reset_midline();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
